// File: rtl/alu_rr_seq_pkg.sv
// Shared types and sizes for the two-port round-robin ALU sequencer.
package alu_rr_seq_pkg;

    localparam int NREQ   = 2;
    localparam int DATA_W = 32;
    localparam int OP_W   = 7;
    localparam int FN_W   = 4;
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_rr_sequencer_if.sv
// Request/response handshakes plus the shared-ALU drive/return signals of the sequencer.
interface alu_rr_sequencer_if;
    import alu_rr_seq_pkg::*;

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [OP_W-1:0]   req0_opcode;
    logic [OP_W-1:0]   req1_opcode;
    logic [FN_W-1:0]   req0_funccode;
    logic [FN_W-1:0]   req1_funccode;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req0_b;
    logic [DATA_W-1:0] req1_b;

    logic [NREQ-1:0]   resp_valid;
    logic [NREQ-1:0]   resp_ready;
    logic [DATA_W-1:0] resp_result;
    logic              resp_branch;

    logic [OP_W-1:0]   alu_opcode;
    logic [FN_W-1:0]   alu_funccode;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_out;
    logic              alu_branch;

    modport slave (
        input  req_valid, req0_opcode, req1_opcode, req0_funccode, req1_funccode,
               req0_a, req1_a, req0_b, req1_b, resp_ready, alu_out, alu_branch,
        output req_ready, resp_valid, resp_result, resp_branch,
               alu_opcode, alu_funccode, alu_a, alu_b
    );

    modport master (
        output req_valid, req0_opcode, req1_opcode, req0_funccode, req1_funccode,
               req0_a, req1_a, req0_b, req1_b, resp_ready, alu_out, alu_branch,
        input  req_ready, resp_valid, resp_result, resp_branch,
               alu_opcode, alu_funccode, alu_a, alu_b
    );

endinterface

// File: rtl/alu_rr_sequencer_rr_pick2.sv
// Combinational 2-way round-robin picker: one-hot grant, ptr breaks ties.
module rr_pick2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant
);

    always_comb begin
        grant = valid;
        if (valid == 2'b11) grant = ptr ? 2'b10 : 2'b01;
    end

endmodule

// File: rtl/alu_rr_sequencer.sv
// Shares one ALUControl/DSPalu pair between two requesters, one operation at a time.
// Optional per-requester completion counters when ALU_RR_SEQ_STATS_EN is defined.
module alu_rr_sequencer
    import alu_rr_seq_pkg::*;
#(
    parameter int unsigned LAT = 0
) (
    input  logic clk,
    input  logic rst,
    alu_rr_sequencer_if.slave bus
`ifdef ALU_RR_SEQ_STATS_EN
    ,
    output logic [31:0] stat_ops0,
    output logic [31:0] stat_ops1
`endif
);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              ptr;
    logic              gnt;
    logic [NREQ-1:0]   pick;
    logic [NREQ-1:0]   ready;
    logic [NREQ-1:0]   resp_vld;
    logic              accept;
    logic              capture;
    logic              done;

    logic [OP_W-1:0]   alu_opcode_p0;
    logic [FN_W-1:0]   alu_funccode_p0;
    logic [DATA_W-1:0] alu_a_p0;
    logic [DATA_W-1:0] alu_b_p0;
    logic [DATA_W-1:0] result_p1;
    logic              branch_p1;

    rr_pick2 u_pick (
        .valid (bus.req_valid),
        .ptr   (ptr),
        .grant (pick)
    );

    assign accept  = |(bus.req_valid & ready);
    assign capture = (state == EXEC) && (cnt == '0);
    assign done    = (state == RESP) && bus.resp_ready[gnt];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)      state_nxt = EXEC;
            EXEC:    if (cnt == '0)   state_nxt = RESP;
            RESP:    if (done)        state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    // Ready is masked during reset so it reads 0 even with requests pending.
    always_comb begin
        ready    = '0;
        resp_vld = '0;
        if (state == IDLE && !rst) ready = pick;
        if (state == RESP)         resp_vld[gnt] = 1'b1;
    end

    // Issue stage: operands latched on accept and held until the next accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt             <= '0;
            gnt             <= 1'b0;
            alu_opcode_p0   <= '0;
            alu_funccode_p0 <= '0;
            alu_a_p0        <= '0;
            alu_b_p0        <= '0;
        end else if (accept) begin
            gnt             <= pick[1];
            cnt             <= CNT_W'(LAT);
            alu_opcode_p0   <= pick[1] ? bus.req1_opcode   : bus.req0_opcode;
            alu_funccode_p0 <= pick[1] ? bus.req1_funccode : bus.req0_funccode;
            alu_a_p0        <= pick[1] ? bus.req1_a        : bus.req0_a;
            alu_b_p0        <= pick[1] ? bus.req1_b        : bus.req0_b;
        end else if (state == EXEC && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Capture stage: result sampled once the settle count expires.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_p1 <= '0;
            branch_p1 <= 1'b0;
            ptr       <= 1'b0;
        end else begin
            if (capture) begin
                result_p1 <= bus.alu_out;
                branch_p1 <= bus.alu_branch;
            end
            if (done) ptr <= ~gnt;
        end
    end

`ifdef ALU_RR_SEQ_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops0 <= '0;
            stat_ops1 <= '0;
        end else if (done) begin
            if (gnt) stat_ops1 <= stat_ops1 + 32'd1;
            else     stat_ops0 <= stat_ops0 + 32'd1;
        end
    end
`endif

    assign bus.req_ready    = ready;
    assign bus.resp_valid   = resp_vld;
    assign bus.resp_result  = result_p1;
    assign bus.resp_branch  = branch_p1;
    assign bus.alu_opcode   = alu_opcode_p0;
    assign bus.alu_funccode = alu_funccode_p0;
    assign bus.alu_a        = alu_a_p0;
    assign bus.alu_b        = alu_b_p0;

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Bench for alu_rr_sequencer: two instances (LAT=0 and LAT=3) driven by directed and random steps.
module tb_alu_rr_sequencer;
    import alu_rr_seq_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]  req_valid    [2];
    logic [1:0]  resp_ready   [2];
    logic [6:0]  req_op       [2][2];
    logic [3:0]  req_fn       [2][2];
    logic [31:0] req_a        [2][2];
    logic [31:0] req_b        [2][2];

    logic [1:0]  req_ready_o  [2];
    logic [1:0]  resp_valid_o [2];
    logic [31:0] result_o     [2];
    logic        branch_o     [2];
    logic [6:0]  alu_op_o     [2];
    logic [3:0]  alu_fn_o     [2];
    logic [31:0] alu_a_o      [2];
    logic [31:0] alu_b_o      [2];
`ifdef ALU_RR_SEQ_STATS_EN
    logic [31:0] stat0        [2];
    logic [31:0] stat1        [2];
`endif

    int vectors     = 0;
    int miscompares = 0;
    bit ptr_m [2];
    int ops_m [2][2];

    // Behavioural stand-in for the shared ALU (RISC-V style function codes).
    function automatic logic [31:0] alu_model(input logic [6:0] op, input logic [3:0] fn,
                                              input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (fn)
            4'b0000: r = a + b;
            4'b1000: r = a - b;
            4'b0001: r = a << b[4:0];
            4'b0010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0011: r = (a < b) ? 32'd1 : 32'd0;
            4'b0100: r = a ^ b;
            4'b0101: r = a >> b[4:0];
            4'b1101: r = 32'($signed(a) >>> b[4:0]);
            4'b0110: r = a | b;
            4'b0111: r = a & b;
            default: r = a + b;
        endcase
        if (op == 7'b1100011) r = a - b;
        return r;
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g
        alu_rr_sequencer_if bus ();
        assign bus.req_valid     = req_valid[k];
        assign bus.resp_ready    = resp_ready[k];
        assign bus.req0_opcode   = req_op[k][0];
        assign bus.req1_opcode   = req_op[k][1];
        assign bus.req0_funccode = req_fn[k][0];
        assign bus.req1_funccode = req_fn[k][1];
        assign bus.req0_a        = req_a[k][0];
        assign bus.req1_a        = req_a[k][1];
        assign bus.req0_b        = req_b[k][0];
        assign bus.req1_b        = req_b[k][1];
        assign bus.alu_out       = alu_model(bus.alu_opcode, bus.alu_funccode, bus.alu_a, bus.alu_b);
        assign bus.alu_branch    = $signed(bus.alu_a) < $signed(bus.alu_b);

        assign req_ready_o[k]  = bus.req_ready;
        assign resp_valid_o[k] = bus.resp_valid;
        assign result_o[k]     = bus.resp_result;
        assign branch_o[k]     = bus.resp_branch;
        assign alu_op_o[k]     = bus.alu_opcode;
        assign alu_fn_o[k]     = bus.alu_funccode;
        assign alu_a_o[k]      = bus.alu_a;
        assign alu_b_o[k]      = bus.alu_b;

        alu_rr_sequencer #(.LAT(k * 3)) dut (
            .clk       (clk),
            .rst       (rst),
            .bus       (bus.slave)
`ifdef ALU_RR_SEQ_STATS_EN
            ,
            .stat_ops0 (stat0[k]),
            .stat_ops1 (stat1[k])
`endif
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int d, input int r, input logic [6:0] op, input logic [3:0] fn,
                           input logic [31:0] a, input logic [31:0] b);
        req_op[d][r]    = op;
        req_fn[d][r]    = fn;
        req_a[d][r]     = a;
        req_b[d][r]     = b;
        req_valid[d][r] = 1'b1;
    endtask

    task automatic check_reset_vals(input int d);
        check("rst_req_ready",  32'(req_ready_o[d]),  32'd0);
        check("rst_resp_valid", 32'(resp_valid_o[d]), 32'd0);
        check("rst_result",     result_o[d],          32'd0);
        check("rst_branch",     32'(branch_o[d]),     32'd0);
        check("rst_alu_opfn",   32'({alu_fn_o[d], alu_op_o[d]}), 32'd0);
        check("rst_alu_a",      alu_a_o[d],           32'd0);
        check("rst_alu_b",      alu_b_o[d],           32'd0);
    endtask

    // Called at a negedge; finishes at the negedge after the response handshake.
    task automatic serve(input int d, input int hold, output logic [31:0] res,
                         output int waited, output int who);
        int r;
        int lat;
        logic [31:0] exp_res;
        logic        exp_br;
        #1;
        r   = (req_valid[d] == 2'b11) ? int'(ptr_m[d]) : (req_valid[d][1] ? 1 : 0);
        who = r;
        waited = 0;
        while (req_ready_o[d] == 2'b00 && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check("req_ready_pick", 32'(req_ready_o[d]), 32'(1) << r);
        exp_res = alu_model(req_op[d][r], req_fn[d][r], req_a[d][r], req_b[d][r]);
        exp_br  = $signed(req_a[d][r]) < $signed(req_b[d][r]);
        @(negedge clk);
        req_valid[d][r] = 1'b0;
        lat = 1;
        while (resp_valid_o[d] == 2'b00 && lat < 20) begin
            check("alu_a_hold",     alu_a_o[d], req_a[d][r]);
            check("alu_b_hold",     alu_b_o[d], req_b[d][r]);
            check("alu_opfn_hold",  32'({alu_fn_o[d], alu_op_o[d]}), 32'({req_fn[d][r], req_op[d][r]}));
            check("req_ready_busy", 32'(req_ready_o[d]), 32'd0);
            @(negedge clk);
            lat++;
        end
        check("latency",    32'(lat), 32'(d * 3 + 2));
        check("resp_valid", 32'(resp_valid_o[d]), 32'(1) << r);
        check("result",     result_o[d], exp_res);
        check("branch",     32'(branch_o[d]), 32'(exp_br));
        res = result_o[d];
        for (int h = 0; h < hold; h++) begin
            resp_ready[d] = 2'(1 << (1 - r));
            @(negedge clk);
            check("bp_resp_valid", 32'(resp_valid_o[d]), 32'(1) << r);
            check("bp_result",     result_o[d], exp_res);
            check("bp_req_ready",  32'(req_ready_o[d]), 32'd0);
        end
        resp_ready[d] = 2'b11;
        @(negedge clk);
        resp_ready[d] = 2'b00;
        check("resp_cleared", 32'(resp_valid_o[d]), 32'd0);
        ptr_m[d] = (r == 0);
        ops_m[d][r]++;
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [6:0] rand_op();
        case ($urandom_range(0, 2))
            0:       return 7'b0110011;
            1:       return 7'b0010011;
            default: return 7'b1100011;
        endcase
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] res;
        int w;
        int who;

        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d]  = 2'b00;
            resp_ready[d] = 2'b00;
            ptr_m[d]      = 1'b0;
            for (int r = 0; r < 2; r++) begin
                req_op[d][r] = '0; req_fn[d][r] = '0; req_a[d][r] = '0; req_b[d][r] = '0;
                ops_m[d][r]  = 0;
            end
        end
        req_valid[0] = 2'b11;
        repeat (3) @(negedge clk);
        check_reset_vals(0);
        check_reset_vals(1);
        req_valid[0] = 2'b00;
        rst = 1'b0;
        @(negedge clk);

        // LAT=0 AND on requester 0
        set_req(0, 0, 7'b0110011, 4'b0111, 32'h0F, 32'h55);
        serve(0, 0, res, w, who);
        check("and_result", res, 32'h05);

        // Simultaneous requests on a fresh pointer: requester 0 wins, 1 follows back-to-back
        set_req(1, 0, 7'b0110011, 4'b1000, 32'd10000, 32'd111);
        set_req(1, 1, 7'b0110011, 4'b0110, 32'h0F, 32'h55);
        serve(1, 0, res, w, who);
        check("sub_winner", 32'(who), 32'd0);
        check("sub_result", res, 32'd9889);
        serve(1, 0, res, w, who);
        check("or_result", res, 32'h5F);
        check("back_to_back_wait", 32'(w), 32'd0);

        // Pointer alternation with both requests kept pending (ptr is 1 after the AND)
        for (int i = 0; i < 4; i++) begin
            for (int r = 0; r < 2; r++)
                if (!req_valid[0][r]) set_req(0, r, 7'b0010011, 4'b0000, $urandom, $urandom);
            serve(0, 0, res, w, who);
            check("alt_winner", 32'(who), (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        while (req_valid[0] != 2'b00) serve(0, 0, res, w, who);

        // LAT=3 SRA on requester 1
        set_req(1, 1, 7'b0110011, 4'b1101, 32'h8, 32'h1);
        serve(1, 0, res, w, who);
        check("sra_result", res, 32'h4);

        // Backpressure with the other request held off
        set_req(0, 0, 7'b0110011, 4'b0100, 32'h1234_5678, 32'h0F0F_0F0F);
        set_req(0, 1, 7'b0110011, 4'b0001, 32'h1, 32'd31);
        serve(0, 10, res, w, who);
        serve(0, 0, res, w, who);

        // Reset while the LAT=3 instance is in EXEC
        set_req(1, 0, 7'b0110011, 4'b0000, 32'h1, 32'h2);
        #1;
        check("rst_mid_accept", 32'(req_ready_o[1]), 32'd1);
        @(negedge clk);
        req_valid[1] = 2'b00;
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals(1);
        check_reset_vals(0);
        rst = 1'b0;
        ptr_m[0] = 1'b0; ptr_m[1] = 1'b0;
        for (int d = 0; d < 2; d++) for (int r = 0; r < 2; r++) ops_m[d][r] = 0;
        repeat (6) begin
            @(negedge clk);
            check("rst_discard", 32'(resp_valid_o[1]), 32'd0);
        end
        set_req(1, 0, 7'b0110011, 4'b0100, 32'h55, 32'hFF);
        serve(1, 0, res, w, who);
        check("xor_result", res, 32'hAA);

        // Randomized traffic, one instance at a time
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 30; i++) begin
                logic [1:0] m;
                m = 2'($urandom_range(1, 3));
                for (int r = 0; r < 2; r++)
                    if (m[r] && !req_valid[d][r])
                        set_req(d, r, rand_op(), 4'($urandom), rand_operand(), rand_operand());
                serve(d, $urandom_range(0, 3), res, w, who);
            end
            while (req_valid[d] != 2'b00) serve(d, 0, res, w, who);
        end

`ifdef ALU_RR_SEQ_STATS_EN
        for (int d = 0; d < 2; d++) begin
            check("stat_ops0", stat0[d], 32'(ops_m[d][0]));
            check("stat_ops1", stat1[d], 32'(ops_m[d][1]));
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
